// File: rtl/game_pkg.sv
// Shared constants and state encoding for the Whac-A-Mole game sequencer and timer.
package game_pkg;

  localparam int unsigned DefGameLengthSeconds = 20;
  localparam int unsigned DefClksPerMs         = 50000;
  localparam int unsigned MsPerSec             = 1000;

  typedef enum logic [2:0] {
    StIdle,
    StReady,
    StPlaying,
    StPaused,
    StGameOver
  } game_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond / second tick generator: prescaler over CLKS_PER_MS plus a 0..999 ms counter.
module ms_tick_gen
  import game_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS = DefClksPerMs
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic ms_tick,
  output logic sec_tick
);

  localparam int unsigned PrescW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  logic [PrescW-1:0] presc_q;
  logic [9:0]        ms_q;

  assign ms_tick  = enable && (presc_q == PrescW'(CLKS_PER_MS - 1));
  assign sec_tick = ms_tick && (ms_q == 10'(MsPerSec - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else if (enable) begin
      if (ms_tick) begin
        presc_q <= '0;
        ms_q    <= sec_tick ? '0 : ms_q + 10'd1;
      end else begin
        presc_q <= presc_q + PrescW'(1);
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// Game sequencer: ready countdown, play/pause, game-over, score and session high score.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned GAME_LENGTH_SECONDS = DefGameLengthSeconds,
  parameter int unsigned CLKS_PER_MS         = DefClksPerMs,
  parameter int unsigned READY_SECONDS       = 3,
  parameter int unsigned SCORE_WIDTH         = 8,
  localparam int unsigned SecW   = $clog2(GAME_LENGTH_SECONDS),
  localparam int unsigned MsW    = $clog2(MsPerSec),
  localparam int unsigned DigitW = $clog2(READY_SECONDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   hit,
  input  logic [SecW-1:0]        count_down_seconds,
  input  logic [MsW-1:0]         count_down_milliseconds,
  output logic                   timer_enable,
  output logic                   timer_rst,
  output logic [DigitW-1:0]      ready_digit,
  output logic                   playing,
  output logic                   game_over,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [SCORE_WIDTH-1:0] high_score
);

  game_state_t            state;
  logic                   tick_clear;
  logic                   sec_tick;
  logic                   unused_ms_tick;
  logic                   timeout;
  logic [SCORE_WIDTH-1:0] score_next;

  // Counters restart on the same edge that enters READY.
  assign tick_clear = start && ((state == StIdle) || (state == StGameOver));
  assign timeout    = (state == StPlaying) && (count_down_seconds == '0)
                      && (count_down_milliseconds == '0);

  always_comb begin
    score_next = score;
    if (hit && (state == StPlaying) && (score != {SCORE_WIDTH{1'b1}})) begin
      score_next = score + SCORE_WIDTH'(1);
    end
  end

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_ms_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (tick_clear),
    .enable  (state == StReady),
    .ms_tick (unused_ms_tick),
    .sec_tick(sec_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      timer_enable <= 1'b0;
      timer_rst    <= 1'b1;
      ready_digit  <= '0;
      playing      <= 1'b0;
      game_over    <= 1'b0;
      score        <= '0;
      high_score   <= '0;
    end else begin
      timer_rst <= 1'b0;
      unique case (state)
        StIdle, StGameOver: begin
          // Keep the timer loaded while idle so it is ready at any start.
          if (state == StIdle) timer_rst <= 1'b1;
          if (start) begin
            state       <= StReady;
            timer_rst   <= 1'b1;
            ready_digit <= DigitW'(READY_SECONDS);
            score       <= '0;
            game_over   <= 1'b0;
          end
        end
        StReady: begin
          if (sec_tick) begin
            if (ready_digit == DigitW'(1)) begin
              state        <= StPlaying;
              ready_digit  <= '0;
              timer_enable <= 1'b1;
              playing      <= 1'b1;
            end else begin
              ready_digit <= ready_digit - DigitW'(1);
            end
          end
        end
        StPlaying: begin
          score <= score_next;
          if (timeout) begin
            state        <= StGameOver;
            timer_enable <= 1'b0;
            playing      <= 1'b0;
            game_over    <= 1'b1;
            if (score_next > high_score) high_score <= score_next;
          end else if (pause) begin
            state        <= StPaused;
            timer_enable <= 1'b0;
            playing      <= 1'b0;
          end
        end
        StPaused: begin
          if (pause) begin
            state        <= StPlaying;
            timer_enable <= 1'b1;
            playing      <= 1'b1;
          end
        end
        default: begin
          state        <= StIdle;
          timer_rst    <= 1'b1;
          timer_enable <= 1'b0;
          playing      <= 1'b0;
          game_over    <= 1'b0;
          ready_digit  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a behavioural count-down timer model.
module tb_game_controller;

  localparam int unsigned GameLen  = 3;
  localparam int unsigned ClksMs   = 2;
  localparam int unsigned ReadySec = 2;
  localparam int unsigned ScoreW   = 8;
  localparam int unsigned SecW     = $clog2(GameLen);
  localparam int unsigned MsW      = $clog2(1000);
  localparam int unsigned DigitW   = $clog2(ReadySec + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic              hit = 1'b0;
  logic [SecW-1:0]   tsec;
  logic [MsW-1:0]    tms;
  int unsigned       tpresc;
  logic              timer_enable;
  logic              timer_rst;
  logic [DigitW-1:0] ready_digit;
  logic              playing;
  logic              game_over;
  logic [ScoreW-1:0] score;
  logic [ScoreW-1:0] high_score;

  int checks = 0;
  int errors = 0;
  int play_cycles;
  logic [SecW-1:0] frz_sec;
  logic [MsW-1:0]  frz_ms;

  always #5 clk = ~clk;

  game_controller #(
    .GAME_LENGTH_SECONDS(GameLen),
    .CLKS_PER_MS        (ClksMs),
    .READY_SECONDS      (ReadySec),
    .SCORE_WIDTH        (ScoreW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .pause                  (pause),
    .hit                    (hit),
    .count_down_seconds     (tsec),
    .count_down_milliseconds(tms),
    .timer_enable           (timer_enable),
    .timer_rst              (timer_rst),
    .ready_digit            (ready_digit),
    .playing                (playing),
    .game_over              (game_over),
    .score                  (score),
    .high_score             (high_score)
  );

  // Count-down timer: loads GameLen s / 0 ms on timer_rst, one ms per ClksMs enabled cycles.
  always @(posedge clk) begin
    if (timer_rst) begin
      tsec   <= SecW'(GameLen);
      tms    <= '0;
      tpresc <= 0;
    end else if (timer_enable) begin
      if (tpresc == ClksMs - 1) begin
        tpresc <= 0;
        if (tms != 0) begin
          tms <= tms - 1'b1;
        end else if (tsec != 0) begin
          tsec <= tsec - 1'b1;
          tms  <= MsW'(999);
        end
      end else begin
        tpresc <= tpresc + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (timer_rst) play_cycles <= 0;
    else if (playing) play_cycles <= play_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
  endtask

  task automatic wait_playing(input int limit);
    int n = 0;
    while (!playing && n < limit) begin
      tick(1);
      n++;
    end
    check("wait_playing", 32'(playing), 1);
  endtask

  task automatic wait_game_over(input int limit);
    int n = 0;
    while (!game_over && n < limit) begin
      tick(1);
      n++;
    end
    check("wait_game_over", 32'(game_over), 1);
  endtask

  initial begin
    // Reset, then idle with stray hit/pause pulses.
    tick(3);
    rst = 1'b0;
    tick(50);
    pulse_hit();
    pulse_pause();
    pulse_hit();
    tick(47);
    check("idle_state", {24'(0), timer_enable, timer_rst, 2'(ready_digit), playing, game_over,
                         2'b0}, {24'(0), 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b0});
    check("idle_score", 32'(score), 0);
    check("idle_high", 32'(high_score), 0);

    // Game 1: ready countdown timing.
    pulse_start();
    check("ready_rst_first", 32'(timer_rst), 1);
    check("ready_digit_load", 32'(ready_digit), 2);
    tick(1);
    check("ready_rst_second", 32'(timer_rst), 0);
    tick(1998);
    check("ready_digit_2000", 32'(ready_digit), 2);
    tick(1);
    check("ready_digit_2001", 32'(ready_digit), 1);
    tick(1999);
    check("ready_not_playing", 32'(playing), 0);
    tick(1);
    check("play_rise", {30'(0), playing, timer_enable}, 3);
    check("play_digit_zero", 32'(ready_digit), 0);

    // Five hits, an ignored start, then pause at 1000 cycles in.
    pulse_hit();
    check("score_one", 32'(score), 1);
    for (int i = 0; i < 4; i++) pulse_hit();
    check("score_five", 32'(score), 5);
    pulse_start();
    check("start_ignored", {23'(0), playing, 8'(score)}, {23'(0), 1'b1, 8'd5});
    tick(993);
    pulse_pause();
    check("paused_outputs", {30'(0), playing, timer_enable}, 0);
    frz_sec = tsec;
    frz_ms  = tms;
    pulse_hit();
    check("paused_hit_dropped", 32'(score), 5);
    tick(2998);
    check("timer_frozen", {16'(frz_sec), 16'(frz_ms)}, {16'(tsec), 16'(tms)});
    check("timer_not_reloaded", 32'(tsec != SecW'(GameLen) || tms != 0), 1);
    pulse_pause();
    check("resume", {30'(0), playing, timer_enable}, 3);
    wait_game_over(8000);
    // 6000 enabled cycles to reach 0/0, plus the cycle that observes it.
    check("play_cycles", 32'(play_cycles), 6001);
    check("g1_score", 32'(score), 5);
    check("g1_high", 32'(high_score), 5);
    check("g1_stopped", {30'(0), playing, timer_enable}, 0);

    // Game 2: start wins over pause in GAME_OVER; hit and pause in the timeout cycle.
    start = 1'b1;
    pause = 1'b1;
    tick(1);
    start = 1'b0;
    pause = 1'b0;
    check("g2_ready", {22'(0), 2'(ready_digit), game_over, timer_rst, 8'(score)},
          {22'(0), 2'd2, 1'b0, 1'b1, 8'd0});
    wait_playing(4100);
    pulse_hit();
    pulse_hit();
    for (int n = 0; n < 7000 && (tsec != 0 || tms != 0); n++) tick(1);
    check("g2_timeout_seen", {30'(0), playing, tsec == 0 && tms == 0}, 3);
    hit   = 1'b1;
    pause = 1'b1;
    tick(1);
    hit   = 1'b0;
    pause = 1'b0;
    check("g2_game_over", {30'(0), game_over, playing}, 2);
    check("g2_score", 32'(score), 3);
    check("g2_high", 32'(high_score), 5);

    // Game 3: saturation, then reset mid-play.
    pulse_start();
    wait_playing(4100);
    for (int i = 0; i < 300; i++) pulse_hit();
    check("score_saturated", 32'(score), 255);
    rst = 1'b1;
    tick(1);
    check("rst_outputs", {24'(0), timer_enable, timer_rst, 2'(ready_digit), playing, game_over,
                          2'b0}, {24'(0), 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b0});
    check("rst_high", 32'(high_score), 0);
    check("rst_score", 32'(score), 0);
    rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
